key_event: RTL and testbench

KEY_EVENT -- requirements
Module: key_event

---
 rtl/key_pkg.sv | 26 ++
 rtl/key_event_if.sv | 28 ++
 rtl/key_event.sv | 116 +++++++++++
 tb/tb_key_event.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key event detector: the FSM state encoding and a
// helper that sizes the hold counter from the two thresholds.
// -----------------------------------------------------------------------------
package key_pkg;

    // States of the key event FSM.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } key_state_e;

    // Counter width able to hold every value from 0 up to max(a,b)-1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 2) begin
            cnt_width = 1;
        end else begin
            cnt_width = $clog2(m);
        end
    endfunction

endpackage : key_pkg

// File: rtl/key_event_if.sv
// -----------------------------------------------------------------------------
// key_event_if
// Bundles the debounced key level and the four event pulses of key_event.
//   debkey      : debounced key level, 1 = pressed
//   press_evt   : one-cycle pulse on a new press
//   short_evt   : one-cycle pulse on release before the long threshold
//   long_evt    : one-cycle pulse when the hold reaches the long threshold
//   repeat_evt  : one-cycle auto-repeat pulse while held after long_evt
// master = side that drives the key level and consumes events,
// slave  = the event detector.
// -----------------------------------------------------------------------------
interface key_event_if;
    logic debkey;
    logic press_evt;
    logic short_evt;
    logic long_evt;
    logic repeat_evt;

    modport master (
        output debkey,
        input  press_evt, short_evt, long_evt, repeat_evt
    );

    modport slave (
        input  debkey,
        output press_evt, short_evt, long_evt, repeat_evt
    );
endinterface : key_event_if

// File: rtl/key_event.sv
// -----------------------------------------------------------------------------
// key_event
// Turns a debounced key level into press / short / long / auto-repeat events.
// A single FSM (IDLE, PRESSED, REPEAT) plus one hold counter; all event
// outputs are registered one-cycle pulses and at most one is high per cycle.
//
// Parameters
//   LONG_CYCLES   : held cycles from press_o to long_o (>= 2)
//   REPEAT_CYCLES : cycles between long_o/repeat_o and the next repeat_o (>= 2)
// Ports
//   clk_i     : clock, rising edge
//   rstn_i    : asynchronous active-low reset
//   debkey_i  : debounced key level, 1 = pressed, synchronous to clk_i
//   press_o   : pulse on a new press
//   short_o   : pulse on release before the long threshold
//   long_o    : pulse when the hold reaches LONG_CYCLES
//   repeat_o  : pulse every REPEAT_CYCLES after long_o while still held
// -----------------------------------------------------------------------------
module key_event
    import key_pkg::*;
#(
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic debkey_i,
    output logic press_o,
    output logic short_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int CNT_W = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    key_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             prev_q;
    logic             press_q;
    logic             short_q;
    logic             long_q;
    logic             repeat_q;
    logic             rise_s;

    // A rise needs a low sample first; prev_q resets to 1 so a key held
    // through reset cannot look like a new press.
    assign rise_s = debkey_i & ~prev_q;

    // Event FSM, hold counter and registered pulse outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prev_q   <= 1'b1;
            press_q  <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            prev_q   <= debkey_i;
            press_q  <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise_s) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                PRESSED: begin
                    // Release is tested first so it wins over the threshold.
                    if (!debkey_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        short_q <= 1'b1;
                    end else if (cnt_q >= LONG_LAST) begin
                        state_q <= REPEAT;
                        cnt_q   <= '0;
                        long_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!debkey_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q >= REP_LAST) begin
                        cnt_q    <= '0;
                        repeat_q <= 1'b1;
                    end else begin
                        cnt_q    <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign press_o  = press_q;
    assign short_o  = short_q;
    assign long_o   = long_q;
    assign repeat_o = repeat_q;

endmodule : key_event

// File: tb/tb_key_event.sv
// -----------------------------------------------------------------------------
// tb_key_event
// Scoreboard bench for key_event with LONG_CYCLES=8, REPEAT_CYCLES=4.
// A reference model derives events from the hold length since the press and
// queues them with their expected cycle; a monitor pops and compares every
// pulse the DUT presents. Directed scenarios also check per-scenario counts.
// -----------------------------------------------------------------------------
module tb_key_event;

    localparam int L = 8;
    localparam int R = 4;

    typedef struct {
        int kind;   // 0 press, 1 short, 2 long, 3 repeat
        int cyc;
    } evt_t;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;
    int   cyc;
    int   obs [4];
    int   base [4];
    evt_t exp_q [$];

    key_event_if kif ();

    key_event #(
        .LONG_CYCLES   (L),
        .REPEAT_CYCLES (R)
    ) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .debkey_i (kif.debkey),
        .press_o  (kif.press_evt),
        .short_o  (kif.short_evt),
        .long_o   (kif.long_evt),
        .repeat_o (kif.repeat_evt)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] outs();
        return {kif.repeat_evt, kif.long_evt, kif.short_evt, kif.press_evt};
    endfunction

    // Reference model: events follow from the number of held edges since the press.
    initial begin : model
        bit holding;
        bit prev;
        int h;
        holding = 1'b0;
        prev    = 1'b1;
        h       = 0;
        cyc     = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rstn) begin
                holding = 1'b0;
                prev    = 1'b1;
            end else begin
                if (!holding) begin
                    if (kif.debkey && !prev) begin
                        exp_q.push_back('{0, cyc});
                        holding = 1'b1;
                        h = 0;
                    end
                end else if (!kif.debkey) begin
                    if (h < L) exp_q.push_back('{1, cyc});
                    holding = 1'b0;
                end else begin
                    h++;
                    if (h == L) exp_q.push_back('{2, cyc});
                    else if (h > L && ((h - L) % R) == 0) exp_q.push_back('{3, cyc});
                end
                prev = kif.debkey;
            end
        end
    end

    // Monitor: sample after each rising edge and match pulses against the queue.
    initial begin : monitor
        logic [3:0] o;
        int k;
        evt_t e;
        forever begin
            @(posedge clk);
            #1;
            o = outs();
            if (o != 4'b0000) begin
                chk("onehot", $countones(o), 1);
                k = o[0] ? 0 : (o[1] ? 1 : (o[2] ? 2 : 3));
                obs[k]++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", k, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", k, e.kind);
                    chk("event_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic drive(input logic lvl, input int n);
        kif.debkey = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic mark();
        for (int i = 0; i < 4; i++) base[i] = obs[i];
    endtask

    task automatic expect_counts(input string nm, input int p, input int s, input int l, input int r);
        chk({nm, "_press"},  obs[0] - base[0], p);
        chk({nm, "_short"},  obs[1] - base[1], s);
        chk({nm, "_long"},   obs[2] - base[2], l);
        chk({nm, "_repeat"}, obs[3] - base[3], r);
    endtask

    task automatic pulse_reset(input int n);
        rstn = 1'b0;
        #1;
        chk("reset_outputs_zero", int'(outs()), 0);
        repeat (n) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin : stim
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 4; i++) begin
            obs[i]  = 0;
            base[i] = 0;
        end
        rstn       = 1'b0;
        kif.debkey = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", int'(outs()), 0);
        rstn = 1'b1;
        drive(1'b0, 3);

        // Short press of 3 cycles.
        mark();
        drive(1'b1, 3);
        drive(1'b0, 4);
        expect_counts("short3", 1, 1, 0, 0);

        // Hold 20 cycles: long at +8, repeats at +12 and +16.
        mark();
        drive(1'b1, 20);
        drive(1'b0, 4);
        expect_counts("hold20", 1, 0, 1, 2);

        // Release on the same edge the long threshold would be reached.
        mark();
        drive(1'b1, 8);
        drive(1'b0, 4);
        expect_counts("release_at_thr", 1, 1, 0, 0);

        // Key held through reset deassertion, then release and press again.
        mark();
        kif.debkey = 1'b1;
        pulse_reset(2);
        drive(1'b1, 30);
        expect_counts("held_thru_reset", 0, 0, 0, 0);
        mark();
        drive(1'b0, 3);
        drive(1'b1, 2);
        drive(1'b0, 4);
        expect_counts("repress", 1, 1, 0, 0);

        // Reset in the middle of a hold aborts it.
        mark();
        drive(1'b1, 5);
        pulse_reset(2);
        drive(1'b1, 15);
        drive(1'b0, 4);
        expect_counts("reset_mid_hold", 1, 0, 0, 0);

        // Single-cycle pulses separated by one low cycle.
        mark();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1);
            drive(1'b0, 1);
        end
        drive(1'b0, 3);
        expect_counts("one_cycle_pulses", 6, 6, 0, 0);

        // Randomized levels and run lengths with occasional resets.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(9, 0) == 0) pulse_reset(int'($urandom_range(2, 1)));
            drive(1'($urandom_range(1, 0)), int'($urandom_range(30, 1)));
        end
        drive(1'b0, 6);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_key_event
